// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel valid/ready multiplexer with a one-word output register.
// Arbitration is either round-robin (mode=0), searching upward from the last
// granted channel, or a fixed select driven by `sel` (mode=1). The output
// register refills on the same edge it drains, so sustained throughput is one
// word per cycle with exactly one cycle of input-to-output latency.
module mux_arb_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  // Registered state: round-robin pointer (last granted channel) and the
  // output word with its source index.
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;

  // Arbitration results for both modes and the selected one.
  logic [N-1:0]     rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic             rr_found;
  logic [SELW-1:0]  rr_cand;
  logic [N-1:0]     fx_grant;
  logic [SELW-1:0]  fx_idx;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_word;

  // Handshake qualifiers.
  logic             load_ok;
  logic             in_xfer;
  logic             out_xfer;

  // Round-robin search: first valid channel after ptr, wrapping N-1 -> 0.
  // The candidate index is formed modulo N so non-power-of-two N never
  // addresses a channel that does not exist.
  always_comb begin
    rr_grant = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      rr_cand = SELW'((int'(ptr_q) + k) % N);
      if (!rr_found && in_valid[rr_cand]) begin
        rr_found         = 1'b1;
        rr_idx           = rr_cand;
        rr_grant[rr_cand] = 1'b1;
      end
    end
  end

  // Fixed select: compare sel against every real channel index, so a sel
  // value of N or more simply matches nothing and produces no grant.
  always_comb begin
    fx_grant = '0;
    fx_idx   = sel;
    for (int i = 0; i < N; i++) begin
      if ((sel == SELW'(i)) && in_valid[i]) begin
        fx_grant[i] = 1'b1;
      end
    end
  end

  // Mode select and word mux; grant is one-hot or zero, so at most one
  // channel's word is picked up.
  always_comb begin
    grant      = mode ? fx_grant : rr_grant;
    grant_idx  = mode ? fx_idx   : rr_idx;
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The output register can take a word when empty or when it drains this
  // cycle. in_ready is forced low during reset so nothing is accepted into
  // a register that is about to be cleared.
  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = (rst || !load_ok) ? '0 : grant;
  assign in_xfer  = |in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // Next-state: load on input transfer (replacing any word draining this
  // cycle), clear valid on a pure drain, otherwise hold. The pointer only
  // advances on a real round-robin transfer, never on a stalled grant.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_word;
      out_ch_d    = grant_idx;
      if (!mode) begin
        ptr_d = grant_idx;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset parks ptr at N-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= SELW'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Testbench for mux_arb_n (N=4, WIDTH=8): directed scenarios with constant
// expectations, then a randomized run against a reference model and a
// scoreboard of accepted words.
module tb_mux_arb_n;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_ch;

  int n_checks = 0;
  int n_pass   = 0;

  mux_arb_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; mode = 1'b0; sel = '0; in_data = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; mode = 1'b0; sel = '0;
    in_data = 32'hFFFF_FFFF;
    cyc();
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready: got %b expected 0000", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", out_data); else n_pass++;
    n_checks++; if (out_ch !== 2'd0) $display("FAIL reset_out_ch: got %0d expected 0", out_ch); else n_pass++;
    cyc();
    mode = 1'b1; sel = 2'd2;
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready_mode1: got %b expected 0000", in_ready); else n_pass++;
  endtask

  task automatic test_rr_all();
    logic [SELW-1:0]  ech;
    logic [WIDTH-1:0] ed;
    do_reset();
    mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL rr_first_grant: got %b expected 0001", in_ready); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      ech = 2'(k % 4);
      ed  = 8'(16 + (k % 4));
      n_checks++; if (out_valid !== 1'b1) $display("FAIL rr_valid k=%0d: got %b expected 1", k, out_valid); else n_pass++;
      n_checks++; if (out_ch !== ech) $display("FAIL rr_out_ch k=%0d: got %0d expected %0d", k, out_ch, ech); else n_pass++;
      n_checks++; if (out_data !== ed) $display("FAIL rr_out_data k=%0d: got %h expected %h", k, out_data, ed); else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    mode = 1'b0; in_valid = 4'b0100; out_ready = 1'b0;
    in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0100) $display("FAIL stall_first_grant: got %b expected 0100", in_ready); else n_pass++;
    for (int s = 0; s < 3; s++) begin
      cyc();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid s=%0d: got %b expected 1", s, out_valid); else n_pass++;
      n_checks++; if (out_data !== 8'hA5) $display("FAIL stall_data s=%0d: got %h expected a5", s, out_data); else n_pass++;
      n_checks++; if (out_ch !== 2'd2) $display("FAIL stall_ch s=%0d: got %0d expected 2", s, out_ch); else n_pass++;
      n_checks++; if (in_ready !== 4'b0000) $display("FAIL stall_in_ready s=%0d: got %b expected 0000", s, in_ready); else n_pass++;
    end
    cyc();
    out_ready = 1'b1;
    in_data[23:16] = 8'hA6;
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0100) $display("FAIL stall_release_ready: got %b expected 0100", in_ready); else n_pass++;
    n_checks++; if (out_data !== 8'hA5) $display("FAIL stall_release_data: got %h expected a5", out_data); else n_pass++;
    cyc();
    in_valid = 4'b0000;
    @(negedge clk);
    n_checks++; if (out_data !== 8'hA6) $display("FAIL stall_next_word: got %h expected a6", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_next_valid: got %b expected 1", out_valid); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA6) $display("FAIL drain_hold_data: got %h expected a6", out_data); else n_pass++;
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b1; sel = 2'd3; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b1000) $display("FAIL fixed_first_ready: got %b expected 1000", in_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      n_checks++; if (in_ready !== 4'b1000) $display("FAIL fixed_ready k=%0d: got %b expected 1000", k, in_ready); else n_pass++;
      n_checks++; if (out_ch !== 2'd3) $display("FAIL fixed_ch k=%0d: got %0d expected 3", k, out_ch); else n_pass++;
      n_checks++; if (out_data !== 8'h13) $display("FAIL fixed_data k=%0d: got %h expected 13", k, out_data); else n_pass++;
    end
    cyc();
    in_valid = 4'b0111;
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL fixed_novalid_ready: got %b expected 0000", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL fixed_last_valid: got %b expected 1", out_valid); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fixed_drained: got %b expected 0", out_valid); else n_pass++;
    cyc();
    mode = 1'b0; in_valid = 4'hF;
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL fixed_ptr_kept: got %b expected 0001", in_ready); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 1'b0; in_valid = 4'b0010; out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL wrap_ch1_grant: got %b expected 0010", in_ready); else n_pass++;
    cyc();
    in_valid = 4'b0011; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL wrap_stall_ready: got %b expected 0000", in_ready); else n_pass++;
    n_checks++; if (out_ch !== 2'd1) $display("FAIL wrap_held_ch: got %0d expected 1", out_ch); else n_pass++;
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL wrap_to_ch0: got %b expected 0001", in_ready); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if (out_ch !== 2'd0) $display("FAIL wrap_out_ch: got %0d expected 0", out_ch); else n_pass++;
    n_checks++; if (out_data !== 8'h10) $display("FAIL wrap_out_data: got %h expected 10", out_data); else n_pass++;
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL wrap_next_ch1: got %b expected 0010", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b0; in_valid = 4'b0001; out_ready = 1'b0;
    in_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    cyc();
    in_valid = 4'b0000;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_held_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h3C) $display("FAIL mid_held_data: got %h expected 3c", out_data); else n_pass++;
    cyc();
    rst = 1'b1; in_valid = 4'hF; in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk);
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b expected 0000", in_ready); else n_pass++;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid_cleared: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL mid_data_cleared: got %h expected 00", out_data); else n_pass++;
    n_checks++; if (out_ch !== 2'd0) $display("FAIL mid_ch_cleared: got %0d expected 0", out_ch); else n_pass++;
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b expected 0001", in_ready); else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++; if (out_data !== 8'h10) $display("FAIL mid_first_word: got %h expected 10", out_data); else n_pass++;
    n_checks++; if (out_ch !== 2'd0) $display("FAIL mid_first_ch: got %0d expected 0", out_ch); else n_pass++;
  endtask

  task automatic test_random();
    logic [9:0]       sb[$];
    logic [9:0]       got;
    logic [9:0]       want;
    logic [N-1:0]     exp_ready;
    logic [WIDTH-1:0] word;
    int  m_ptr;
    bit  m_ov;
    bit  has;
    int  idx;
    int  c;
    do_reset();
    m_ptr = N - 1;
    m_ov  = 1'b0;
    for (int cy = 0; cy < 10000; cy++) begin
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = 2'($urandom);
      in_data   = $urandom;
      @(negedge clk);
      has = 1'b0;
      idx = 0;
      if (mode) begin
        idx = int'(sel);
        has = in_valid[idx];
      end else begin
        for (int j = 1; j <= N; j++) begin
          c = (m_ptr + j) % N;
          if (!has && in_valid[c]) begin
            has = 1'b1;
            idx = c;
          end
        end
      end
      exp_ready = (has && (!m_ov || out_ready)) ? 4'(1 << idx) : 4'b0000;
      n_checks++; if (in_ready !== exp_ready) $display("FAIL rand_in_ready cy=%0d: got %b expected %b", cy, in_ready, exp_ready); else n_pass++;
      n_checks++; if ($countones(in_ready) > 1) $display("FAIL rand_onehot cy=%0d: got %b expected at most one bit", cy, in_ready); else n_pass++;
      n_checks++; if (out_valid !== m_ov) $display("FAIL rand_out_valid cy=%0d: got %b expected %b", cy, out_valid, m_ov); else n_pass++;
      if (m_ov && out_ready) begin
        got = {out_ch, out_data};
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL rand_extra_output cy=%0d: got %h expected no word", cy, got);
        end else begin
          want = sb.pop_front();
          if (got !== want) $display("FAIL rand_word cy=%0d: got ch%0d/%h expected ch%0d/%h", cy, got[9:8], got[7:0], want[9:8], want[7:0]);
          else n_pass++;
        end
      end
      if (exp_ready != 4'b0000) begin
        word = in_data[idx*WIDTH +: WIDTH];
        sb.push_back({2'(idx), word});
        if (!mode) m_ptr = idx;
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      cyc();
    end
    n_checks++; if (sb.size() != (m_ov ? 1 : 0)) $display("FAIL rand_sb_residue: got %0d expected %0d", sb.size(), m_ov ? 1 : 0); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; mode = 1'b0; sel = '0; in_data = '0;
    test_reset();
    test_rr_all();
    test_stall();
    test_fixed();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
